// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the load/store memory controller: FSM state
// encoding, access direction codes, write-back constants and small helpers.
// Ports: none (package).
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_t;

  localparam logic        MEM_READ  = 1'b0;
  localparam logic        MEM_WRITE = 1'b1;

  localparam logic [4:0]  REG_X0    = 5'd0;
  localparam logic [31:0] DATA_ZERO = 32'd0;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;

  localparam int unsigned CNT_W     = 8;

  // Only the two low address bits decide word alignment.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
// 8-bit wait counter used by mem_ctrl to bound the time spent waiting on the
// bus. It counts enabled cycles since the last clear and flags when the
// count has reached TIMEOUT.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the count at zero (wins over enable)
//   enable      count this cycle
//   expired     count has reached TIMEOUT
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Counting stops once the limit is hit so the flag cannot wrap away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Memory stage controller: forwards ALU results to write-back, and turns
// load/store requests from execute into a single request/grant/response bus
// transaction, stalling the pipeline while the bus is busy. Misaligned
// accesses are dropped with a pulse; bus waits are bounded by TIMEOUT.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_ena_i/rw/addr/data     access request from execute
//   gprs_waddr_i/gprs_wdata_i  ALU/jump result and destination register
//   bus_req_o/we/addr/wdata    bus request side
//   bus_gnt_i                  request accepted this cycle
//   bus_rvalid_i/bus_rdata_i   read response
//   stall_o                    hold upstream pipeline registers
//   gprs_waddr_o/gprs_wdata_o  registered write-back
//   misalign_o, bus_err_o      one-cycle error pulses
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ena_i,
  input  logic        mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  gprs_waddr_i,
  input  logic [31:0] gprs_wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [4:0]  gprs_waddr_o,
  output logic [31:0] gprs_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  mem_state_t  state;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [4:0]  waddr_q;

  logic aligned;
  logic is_write;
  logic expired;
  logic stall_c;
  logic cnt_clear;
  logic cnt_enable;

  assign aligned  = is_word_aligned(mem_addr_i[1:0]);
  assign is_write = (rw_q == MEM_WRITE);

  // A response in the same cycle as expiry wins: the transfer completes.
  always_comb begin
    stall_c = DISABLE;
    unique case (state)
      IDLE:    stall_c = mem_ena_i && aligned;
      REQ:     stall_c = bus_gnt_i ? !is_write : !expired;
      WAIT_R:  stall_c = !bus_rvalid_i && !expired;
      default: stall_c = DISABLE;
    endcase
  end

  // Stall is combinational, so it is also masked while reset is asserted.
  assign stall_o = stall_c && rst_n;

  // Held at zero through IDLE, so the count starts fresh on entering REQ;
  // the grant restarts it for the read-response wait.
  assign cnt_clear  = (state == IDLE) || ((state == REQ) && bus_gnt_i);
  assign cnt_enable = stall_c && (state != IDLE);

  mem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  assign bus_req_o   = (state == REQ);
  assign bus_we_o    = rw_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = data_q;

  // Write-back defaults to x0 every cycle; only a plain ALU cycle in IDLE or
  // a returning load writes a real register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rw_q         <= MEM_READ;
      addr_q       <= DATA_ZERO;
      data_q       <= DATA_ZERO;
      waddr_q      <= REG_X0;
      gprs_waddr_o <= REG_X0;
      gprs_wdata_o <= DATA_ZERO;
      misalign_o   <= DISABLE;
      bus_err_o    <= DISABLE;
    end else begin
      gprs_waddr_o <= REG_X0;
      gprs_wdata_o <= DATA_ZERO;
      misalign_o   <= DISABLE;
      bus_err_o    <= DISABLE;
      unique case (state)
        IDLE: begin
          if (!mem_ena_i) begin
            gprs_waddr_o <= gprs_waddr_i;
            gprs_wdata_o <= gprs_wdata_i;
          end else if (aligned) begin
            rw_q    <= mem_rw_i;
            addr_q  <= {mem_addr_i[31:2], 2'b00};
            data_q  <= mem_data_i;
            waddr_q <= gprs_waddr_i;
            state   <= REQ;
          end else begin
            misalign_o <= ENABLE;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            state <= is_write ? IDLE : WAIT_R;
          end else if (expired) begin
            bus_err_o <= ENABLE;
            state     <= IDLE;
          end
        end
        WAIT_R: begin
          if (bus_rvalid_i) begin
            gprs_waddr_o <= waddr_q;
            gprs_wdata_o <= bus_rdata_i;
            state        <= IDLE;
          end else if (expired) begin
            bus_err_o <= ENABLE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. Each operation is described at
// transaction level (kind, address, data, grant delay, response delay) and
// the expected per-cycle stall/request and registered write-back values are
// worked out from the controller's rules, then compared cycle by cycle.
module tb_mem_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int KIND_ALU   = 0;
  localparam int KIND_LOAD  = 1;
  localparam int KIND_STORE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ena_i;
  logic        mem_rw_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [4:0]  gprs_waddr_i;
  logic [31:0] gprs_wdata_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o;
  logic [4:0]  gprs_waddr_o;
  logic [31:0] gprs_wdata_o;
  logic        misalign_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;
  int stall_seen;

  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        exp_mis;
  logic        exp_err;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;

  mem_ctrl #(
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ena_i   (mem_ena_i),
    .mem_rw_i    (mem_rw_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .gprs_waddr_i(gprs_waddr_i),
    .gprs_wdata_i(gprs_wdata_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_gnt_i   (bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i),
    .stall_o     (stall_o),
    .gprs_waddr_o(gprs_waddr_o),
    .gprs_wdata_o(gprs_wdata_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Execute-side inputs are don't-care while a transaction is in flight.
  task automatic driveGarbage();
    mem_ena_i    = 1'($urandom);
    mem_rw_i     = 1'($urandom);
    mem_addr_i   = $urandom;
    mem_data_i   = $urandom;
    gprs_waddr_i = 5'($urandom);
    gprs_wdata_i = $urandom;
  endtask

  // Check the current cycle at the falling edge, then advance one clock and
  // load the registered outputs expected after that edge.
  task automatic stepCycle(input logic e_stall, input logic e_req,
                           input logic [4:0] n_waddr, input logic [31:0] n_wdata,
                           input logic n_mis, input logic n_err);
    @(negedge clk);
    checkOutput("stall", 32'(stall_o), 32'(e_stall));
    checkOutput("bus_req", 32'(bus_req_o), 32'(e_req));
    checkOutput("wb_addr", 32'(gprs_waddr_o), 32'(exp_waddr));
    checkOutput("wb_data", gprs_wdata_o, exp_wdata);
    checkOutput("misalign", 32'(misalign_o), 32'(exp_mis));
    checkOutput("bus_err", 32'(bus_err_o), 32'(exp_err));
    if (e_req) begin
      checkOutput("bus_we", 32'(bus_we_o), 32'(cur_we));
      checkOutput("bus_addr", bus_addr_o, cur_addr);
      if (cur_we) checkOutput("bus_wdata", bus_wdata_o, cur_data);
    end
    if (stall_o) stall_seen++;
    @(posedge clk);
    exp_waddr = n_waddr;
    exp_wdata = n_wdata;
    exp_mis   = n_mis;
    exp_err   = n_err;
    #1;
  endtask

  // g = REQ cycles without grant before the grant, r = WAIT_R cycles
  // without response; a delay beyond TB_TIMEOUT means it never arrives.
  task automatic applyStimulus(input int kind, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] waddr,
                               input logic [31:0] wdata, input int g, input int r,
                               input logic [31:0] rdata);
    bit done;
    bit read_granted;
    stall_seen   = 0;
    done         = 0;
    read_granted = 0;
    mem_ena_i    = (kind != KIND_ALU);
    mem_rw_i     = (kind == KIND_STORE);
    mem_addr_i   = addr;
    mem_data_i   = data;
    gprs_waddr_i = waddr;
    gprs_wdata_i = wdata;
    bus_gnt_i    = 1'($urandom);
    bus_rvalid_i = 1'($urandom);
    bus_rdata_i  = $urandom;
    if (kind == KIND_ALU) begin
      stepCycle(1'b0, 1'b0, waddr, wdata, 1'b0, 1'b0);
    end else if (addr[1:0] != 2'b00) begin
      stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    end else begin
      cur_we   = (kind == KIND_STORE);
      cur_addr = addr;
      cur_data = data;
      stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k <= int'(TB_TIMEOUT) && !done; k++) begin
        driveGarbage();
        bus_gnt_i    = (k == g);
        bus_rvalid_i = 1'($urandom);
        bus_rdata_i  = $urandom;
        if (k == g) begin
          done = 1;
          read_granted = !cur_we;
          stepCycle(!cur_we, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
        end else if (k == int'(TB_TIMEOUT)) begin
          done = 1;
          stepCycle(1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b1);
        end else begin
          stepCycle(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
        end
      end
      done = !read_granted;
      for (int j = 0; j <= int'(TB_TIMEOUT) && !done; j++) begin
        driveGarbage();
        bus_gnt_i    = 1'($urandom);
        bus_rvalid_i = (j == r);
        bus_rdata_i  = (j == r) ? rdata : $urandom;
        if (j == r) begin
          done = 1;
          stepCycle(1'b0, 1'b0, waddr, rdata, 1'b0, 1'b0);
        end else if (j == int'(TB_TIMEOUT)) begin
          done = 1;
          stepCycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        end else begin
          stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        end
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, "_req"}, 32'(bus_req_o), 32'd0);
    checkOutput({tag, "_we"}, 32'(bus_we_o), 32'd0);
    checkOutput({tag, "_addr"}, bus_addr_o, 32'd0);
    checkOutput({tag, "_wdata"}, bus_wdata_o, 32'd0);
    checkOutput({tag, "_wb_addr"}, 32'(gprs_waddr_o), 32'd0);
    checkOutput({tag, "_wb_data"}, gprs_wdata_o, 32'd0);
    checkOutput({tag, "_mis"}, 32'(misalign_o), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus_err_o), 32'd0);
  endtask

  initial begin
    int kind;
    int g;
    int r;
    logic [31:0] addr;

    rst_n        = 1'b0;
    mem_ena_i    = 1'b1;
    mem_rw_i     = 1'b0;
    mem_addr_i   = 32'h0000_0100;
    mem_data_i   = 32'd0;
    gprs_waddr_i = 5'd0;
    gprs_wdata_i = 32'd0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'd0;
    exp_waddr = 5'd0; exp_wdata = 32'd0; exp_mis = 1'b0; exp_err = 1'b0;
    cur_we = 1'b0; cur_addr = 32'd0; cur_data = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(KIND_ALU, 32'd0, 32'd0, 5'd5, 32'h0000_1234, 0, 0, 32'd0);
    checkOutput("alu_stall_cycles", stall_seen, 0);
    applyStimulus(KIND_LOAD, 32'h0000_0100, 32'd0, 5'd7, 32'd0, 2, 2, 32'hDEAD_BEEF);
    checkOutput("load_stall_cycles", stall_seen, 6);
    applyStimulus(KIND_STORE, 32'h0000_0200, 32'hA5A5_A5A5, 5'd9, 32'd0, 0, 0, 32'd0);
    checkOutput("store_stall_cycles", stall_seen, 1);
    applyStimulus(KIND_LOAD, 32'h0000_0102, 32'd0, 5'd3, 32'd0, 0, 0, 32'd0);
    checkOutput("misalign_stall_cycles", stall_seen, 0);
    applyStimulus(KIND_LOAD, 32'h0000_0300, 32'd0, 5'd4, 32'd0, 0, 99, 32'd0);
    // Late response after the timeout must not reach write-back.
    mem_ena_i = 1'b0; gprs_waddr_i = 5'd6; gprs_wdata_i = 32'h0000_0066;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    stepCycle(1'b0, 1'b0, 5'd6, 32'h0000_0066, 1'b0, 1'b0);
    applyStimulus(KIND_LOAD, 32'h0000_0400, 32'd0, 5'd0, 32'd0, 1, 1, 32'h1357_9BDF);
    applyStimulus(KIND_LOAD, 32'h0000_0500, 32'd0, 5'd8, 32'd0, 9, 0, 32'd0);

    $display("[TB] reset during read wait");
    mem_ena_i = 1'b1; mem_rw_i = 1'b0; mem_addr_i = 32'h0000_0600;
    gprs_waddr_i = 5'd10; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    cur_we = 1'b0; cur_addr = 32'h0000_0600;
    stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    bus_gnt_i = 1'b1;
    stepCycle(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0);
    bus_gnt_i = 1'b0;
    stepCycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 checkAllZero("midreset");
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_waddr = 5'd0; exp_wdata = 32'd0; exp_mis = 1'b0; exp_err = 1'b0;
    mem_ena_i = 1'b0; gprs_waddr_i = 5'd3; gprs_wdata_i = 32'h0000_0055;
    stepCycle(1'b0, 1'b0, 5'd3, 32'h0000_0055, 1'b0, 1'b0);
    applyStimulus(KIND_LOAD, 32'h0000_0700, 32'd0, 5'd11, 32'd0, 0, 0, 32'hCAFE_F00D);

    $display("[TB] randomized operations");
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      g = ($urandom_range(0, 7) == 0) ? int'(TB_TIMEOUT) + 1 : int'($urandom_range(0, TB_TIMEOUT));
      r = ($urandom_range(0, 7) == 0) ? int'(TB_TIMEOUT) + 1 : int'($urandom_range(0, TB_TIMEOUT));
      applyStimulus(kind, addr, $urandom, 5'($urandom), $urandom, g, r, $urandom);
    end
    applyStimulus(KIND_ALU, 32'd0, 32'd0, 5'd1, 32'd1, 0, 0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for bus_gnt_i or bus_rvalid_i before error.
REQ-002 Ports SHALL be, clock and reset first:
 clk  in  1  single clock, all state on rising edge
 rst_n  in  1  asynchronous, active-low reset
 mem_ena_i  in  1  memory access request from execute stage
 mem_rw_i  in  1  MEM_READ=0 / MEM_WRITE=1
 mem_addr_i  in  32  byte address
 mem_data_i  in  32  store data
 gprs_waddr_i  in  5  destination register (x0 = none)
 gprs_wdata_i  in  32  ALU/jump result
 bus_req_o  out  1  bus request valid
 bus_we_o  out  1  1 = write
 bus_addr_o  out  32  word-aligned address
 bus_wdata_o  out  32  write data
 bus_gnt_i  in  1  request accepted this cycle
 bus_rvalid_i  in  1  read data valid
 bus_rdata_i  in  32  read data
 stall_o  out  1  hold upstream pipeline registers
 gprs_waddr_o  out  5  registered write-back address
 gprs_wdata_o  out  32  registered write-back data
 misalign_o  out  1  one-cycle pulse: misaligned access dropped
 bus_err_o  out  1  one-cycle pulse: bus timeout

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT_R.
REQ-004 IDLE, mem_ena_i=0: next cycle gprs_waddr_o/gprs_wdata_o SHALL equal gprs_waddr_i/gprs_wdata_i (1-cycle latency), stall_o=0.
REQ-005 IDLE, mem_ena_i=1, mem_addr_i[1:0]=0: stall_o SHALL be 1 combinationally; rw, addr, data, gprs_waddr_i SHALL be latched; go REQ; write-back that edge SHALL be x0.
REQ-006 IDLE, mem_ena_i=1, mem_addr_i[1:0]!=0: no bus access, stall_o=0, misalign_o=1 next cycle, write-back x0.
REQ-007 REQ: bus_req_o=1 with latched bus_we_o/bus_addr_o/bus_wdata_o held stable until bus_gnt_i; stall_o=1 unless bus_gnt_i and write.
REQ-008 REQ with bus_gnt_i, write: go IDLE, stall_o=0 that cycle, write-back x0.
REQ-009 REQ with bus_gnt_i, read: go WAIT_R; bus_rvalid_i SHALL be ignored in REQ (earliest valid response is the cycle after grant).
REQ-010 WAIT_R: bus_req_o=0; stall_o=1 except in the cycle bus_rvalid_i=1, when stall_o=0, gprs_wdata_o<=bus_rdata_i, gprs_waddr_o<=latched address, go IDLE.
REQ-011 Inputs from execute SHALL be ignored in REQ and WAIT_R.
REQ-012 An 8-bit wait counter SHALL clear on entering REQ and WAIT_R, increment each stalled cycle; on reaching TIMEOUT: bus_err_o=1 next cycle, stall_o=0 that cycle, write-back x0, go IDLE.
REQ-013 bus_req_o, stall_o SHALL be 0 in IDLE except per REQ-005 (bus_req_o always 0 in IDLE).
REQ-014 Load to x0 SHALL complete the bus read but produce gprs_waddr_o=x0.

Reset
REQ-015 rst_n=0 SHALL asynchronously force IDLE, counter 0, all outputs 0 (gprs_waddr_o=x0), including mid-REQ/WAIT_R; a pending bus transaction SHALL be abandoned and any later bus_rvalid_i ignored.

Structure
REQ-016 State encodings, MEM_READ/MEM_WRITE, REG_X0, DATA_ZERO, ENABLE/DISABLE SHALL come from the shared common definitions.
REQ-017 The wait counter SHALL be a separate sub-module mem_timeout_cnt (clear, enable, expired).

Verification
REQ-018 ALU op x5<=0x1234, mem_ena_i=0 -> next cycle gprs_waddr_o=5, gprs_wdata_o=0x1234, stall_o never 1.
REQ-019 Load x7 from 0x100, gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> bus_addr_o=0x100, we=0, stall_o high 6 cycles, then gprs x7=0xDEADBEEF.
REQ-020 Store 0xA5A5A5A5 to 0x200, gnt immediate -> single bus_req_o cycle, we=1, stall_o high 1 cycle, write-back x0.
REQ-021 Load from 0x102 -> no bus_req_o, misalign_o pulse, stall_o=0.
REQ-022 TIMEOUT=4, read granted, no rvalid -> bus_err_o pulse after 4 wait cycles, FSM IDLE; late rvalid ignored.
REQ-023 rst_n low during WAIT_R -> outputs 0 immediately, IDLE after release, next load completes normally.
